seq_detect_param: RTL and testbench

- Parametrised, runtime-programmable serial bit-sequence detector. Successor to the team's fixed 5-bit Mealy detector for 11101.
- Pattern length up to MAXLEN, with overlap or non-overlap mode selectable per configuration.
- Mealy match output plus a registered copy, a saturating match counter, and a valid qualifier on the serial input.
- Sits on a serial bitstream path, e.g. frame-sync or preamble hunting, ahead of deframing logic.

---
 rtl/seq_detect_pkg.sv | 20 ++
 rtl/seq_match_cmp.sv | 19 +
 rtl/seq_detect_param.sv | 89 ++++++++
 tb/tb_seq_detect_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector family.
package seq_detect_pkg;

  localparam int unsigned MAXLEN_DEF = 8;
  localparam int unsigned LENW_DEF   = 4;
  localparam int unsigned CNTW_DEF   = 16;
  localparam int unsigned MASK_MAXW  = 64;

  // Lengths above the hardware maximum behave as the maximum.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned maxlen);
    return (len > maxlen) ? maxlen : len;
  endfunction

  // Low 'len' bits set; callers truncate to their own pattern width.
  function automatic logic [MASK_MAXW-1:0] len_mask(input int unsigned len);
    if (len >= MASK_MAXW) return '1;
    return (MASK_MAXW'(1) << len) - MASK_MAXW'(1);
  endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked window comparator: eq when the low len bits of window equal those of pat.
module seq_match_cmp
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned LENW   = LENW_DEF
) (
  input  logic [MAXLEN-1:0] window,
  input  logic [MAXLEN-1:0] pat,
  input  logic [LENW-1:0]   len,
  output logic              eq
);

  logic [MAXLEN-1:0] mask;

  assign mask = MAXLEN'(len_mask(32'(len)));
  assign eq   = ((window ^ pat) & mask) == '0;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with Mealy match, registered copy
// and saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEF,
  parameter int unsigned LENW   = LENW_DEF,
  parameter int unsigned CNTW   = CNTW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              datain,
  input  logic              din_valid,
  input  logic              cfg_load,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic              cnt_clr,
  output logic              dataout,
  output logic              match_q,
  output logic [CNTW-1:0]   match_count
);

  localparam int unsigned FILLW = $clog2(MAXLEN + 1);

  logic [MAXLEN-1:0] pat;
  logic [LENW-1:0]   len;
  logic              ovl;
  logic [MAXLEN-2:0] hist;
  logic [FILLW-1:0]  fill;

  logic [MAXLEN-1:0] window;
  logic              accept;
  logic              fill_ok;
  logic              eq;

  assign window  = {hist, datain};
  assign accept  = din_valid & ~cfg_load;
  assign fill_ok = (32'(fill) + 32'd1) >= 32'(len);
  assign dataout = accept & (len != '0) & fill_ok & eq;

  seq_match_cmp #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_cmp (
    .window (window),
    .pat    (pat),
    .len    (len),
    .eq     (eq)
  );

  // Config, history window, fill tracking and match counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat         <= '0;
      len         <= '0;
      ovl         <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_q     <= 1'b0;
      match_count <= '0;
    end else begin
      match_q <= dataout;

      if (cnt_clr) begin
        match_count <= '0;
      end else if (dataout && (match_count != '1)) begin
        match_count <= match_count + CNTW'(1);
      end

      if (cfg_load) begin
        pat  <= cfg_pattern;
        len  <= LENW'(clamp_len(32'(cfg_len), MAXLEN));
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (din_valid) begin
        hist <= window[MAXLEN-2:0];
        // Non-overlap restart: the next match needs a full set of fresh bits.
        if (dataout && !ovl) begin
          fill <= '0;
        end else if (32'(fill) < MAXLEN) begin
          fill <= fill + FILLW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed self-checking bench for seq_detect_param against a queue-based model.
module tb_seq_detect_param;

  logic        clock;
  logic        reset;
  logic        datain;
  logic        din_valid;
  logic        cfg_load;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        cfg_overlap;
  logic        cnt_clr;
  logic        dataout;
  logic        match_q;
  logic [15:0] match_count;
  logic        dataout2;
  logic        match_q2;
  logic [1:0]  match_count2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: accepted bits since restart, newest at the back.
  bit       q[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_q;
  int       m_cnt;
  int       m_cnt2;
  logic     last_dout;

  seq_detect_param #(.MAXLEN(8), .LENW(4), .CNTW(16)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .datain      (datain),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .dataout     (dataout),
    .match_q     (match_q),
    .match_count (match_count)
  );

  seq_detect_param #(.MAXLEN(8), .LENW(4), .CNTW(2)) u_dut_sat (
    .clock       (clock),
    .reset       (reset),
    .datain      (datain),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .dataout     (dataout2),
    .match_q     (match_q2),
    .match_count (match_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pat  = '0;
    m_len  = 0;
    m_ovl  = 1'b0;
    m_q    = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endfunction

  // Match when the last m_len received bits (ending with d) spell the pattern.
  function automatic bit model_dout(input bit v, input bit ld, input bit d);
    if (!v || ld || m_len == 0) return 1'b0;
    if (q.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      bit b;
      b = (i == 0) ? d : q[q.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_update(input bit v, input bit ld, input bit d, input bit clr,
                                       input bit hit);
    m_q = hit;
    if (clr) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (ld) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
      m_ovl = cfg_overlap;
      q.delete();
    end else if (v) begin
      if (hit && !m_ovl) begin
        q.delete();
      end else begin
        q.push_back(d);
        if (q.size() > 8) void'(q.pop_front());
      end
    end
  endfunction

  // One clock: drive, check mid-cycle, then advance the model on the edge.
  task automatic step(input bit v, input bit d, input bit ld, input bit clr);
    bit hit;
    din_valid = v;
    datain    = d;
    cfg_load  = ld;
    cnt_clr   = clr;
    @(negedge clock);
    hit = model_dout(v, ld, d);
    chk("dataout", 32'(dataout), 32'(hit));
    chk("dataout_sat", 32'(dataout2), 32'(hit));
    chk("match_q", 32'(match_q), 32'(m_q));
    chk("match_count", 32'(match_count), 32'(m_cnt));
    chk("match_count_sat", 32'(match_count2), 32'(m_cnt2));
    last_dout = dataout;
    @(posedge clock);
    model_update(v, ld, d, clr, hit);
    #1;
  endtask

  // Send n bits MSB first; hits bit i is set when bit i (0 = first) matched.
  task automatic send(input logic [31:0] bits, input int n, input int gap,
                      output logic [31:0] hits, output int idle_hits);
    hits      = '0;
    idle_hits = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0, 1'b0);
      hits[i] = last_dout;
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        if (last_dout) idle_hits++;
      end
    end
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [31:0] hits;
  int          idle;

  initial begin
    reset       = 1'b0;
    datain      = 1'b0;
    din_valid   = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    model_reset();
    #3;
    chk("reset_dataout", 32'(dataout), 32'd0);
    chk("reset_match_q", 32'(match_q), 32'd0);
    chk("reset_count", 32'(match_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Disabled detector after reset never matches.
    send(32'h1d, 5, 0, hits, idle);
    chk("disabled_hits", hits, 32'h0);

    load(8'b11101, 4'd5, 1'b1);
    send(32'b111011101, 9, 0, hits, idle);
    chk("ovl_11101_hits", hits, 32'h110);
    chk("ovl_11101_cnt", 32'(match_count), 32'd2);

    load(8'b11101, 4'd5, 1'b0);
    send(32'b111011101, 9, 0, hits, idle);
    chk("novl_11101_hits", hits, 32'h10);
    chk("novl_11101_cnt", 32'(match_count), 32'd1);

    load(8'b1010, 4'd4, 1'b1);
    send(32'b1010101, 7, 0, hits, idle);
    chk("ovl_1010_hits", hits, 32'h28);

    load(8'b1010, 4'd4, 1'b0);
    send(32'b1010101, 7, 0, hits, idle);
    chk("novl_1010_hits", hits, 32'h8);

    load(8'b11101, 4'd5, 1'b1);
    send(32'b11101, 5, 3, hits, idle);
    chk("gap_hits", hits, 32'h10);
    chk("gap_idle_hits", 32'(idle), 32'd0);
    chk("gap_cnt", 32'(match_count), 32'd1);

    // Reload lands on the final bit of 11101: that bit is discarded.
    load(8'b11101, 4'd5, 1'b1);
    send(32'b1110, 4, 0, hits, idle);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("load_final_dout", 32'(last_dout), 32'd0);
    send(32'b1110, 4, 0, hits, idle);
    chk("after_load_hits", hits, 32'h0);
    chk("after_load_cnt", 32'(match_count), 32'd0);

    load(8'h00, 4'd0, 1'b1);
    send($urandom, 20, 0, hits, idle);
    chk("len0_hits", hits, 32'h0);

    load(8'b10110011, 4'd15, 1'b0);
    send(32'b010110011, 9, 0, hits, idle);
    chk("len15_hits", hits, 32'h100);
    chk("len15_cnt", 32'(match_count), 32'd1);

    load(8'b11101, 4'd5, 1'b1);
    send(32'b11101110111011101, 17, 0, hits, idle);
    chk("sat_hits", hits, 32'h11110);
    chk("sat_cnt16", 32'(match_count), 32'd4);
    chk("sat_cnt2", 32'(match_count2), 32'd3);

    // Asynchronous reset between edges, with match_q still high from the last match.
    #2;
    din_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("areset_dataout", 32'(dataout), 32'd0);
    chk("areset_match_q", 32'(match_q), 32'd0);
    chk("areset_count", 32'(match_count), 32'd0);
    chk("areset_count_sat", 32'(match_count2), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    load(8'b1011, 4'd4, 1'b0);
    send(32'b1011, 4, 0, hits, idle);
    chk("post_reset_hits", hits, 32'h8);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) != 0) cfg_len = 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else begin
        step(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'b0,
             ($urandom_range(0, 39) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
